// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums a group of signed 64-bit products into a wide accumulator and presents
// the group sum downstream over a valid/ready handshake. A group closes after
// LEN products or on an earlier product flagged with in_last. While the result
// is held the block stalls its input. After the result is taken it restarts
// from an empty group.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   product present on in_z
//   in_ready   block accepts a product this cycle (a function of state only)
//   in_z       signed two's-complement product
//   in_last    the product on in_z closes the current group
//   out_valid  group sum present on out_acc/out_cnt
//   out_ready  downstream accepts the group sum
//   out_acc    signed group sum (registered)
//   out_cnt    number of products in the group, 1..LEN (registered)
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int LEN   = 8,
  parameter int ACC_W = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_z,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [8:0]       out_cnt
);

  localparam logic ACCUM = 1'b0;
  localparam logic HOLD  = 1'b1;

  localparam logic [8:0] LEN_CNT = 9'(LEN);

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [8:0]       cnt_q, cnt_d;
  // Held low through reset so in_ready rises only on the first edge after
  // reset is released.
  logic             ready_q, ready_d;

  logic             in_fire;
  logic [ACC_W-1:0] z_ext;

  assign in_ready  = ready_q && (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign in_fire   = in_valid && in_ready;
  assign z_ext     = {{(ACC_W-64){in_z[63]}}, in_z};

  // The accumulator doubles as the result register: it holds the final sum
  // through HOLD and is cleared on the output transfer.
  assign out_acc = acc_q;
  assign out_cnt = cnt_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;

    case (state_q)
      ACCUM: begin
        if (in_fire) begin
          acc_d = acc_q + z_ext;
          cnt_d = cnt_q + 9'd1;
          // in_last on the LEN-th product is the same single close.
          if (in_last || (cnt_d == LEN_CNT)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Self-checking bench for product_accumulator (LEN=8, ACC_W=72). A reference
// model keeps the open group as a queue of products; when the group closes the
// expected result is the arithmetic sum of the queue and its size. Directed
// groups come from a vector table; backpressure, bubbles and mid-group reset
// are hand-written sequences; a random phase runs against the model.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int LEN   = 8;
  localparam int ACC_W = 72;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_z;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [8:0]       out_cnt;

  product_accumulator #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [ACC_W-1:0] act,
                       input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic signed [63:0] grp[$];      // products of the open group
  bit                 m_started;   // an edge has passed since reset release
  bit                 m_hold;      // a result is waiting downstream
  logic [ACC_W-1:0]   m_sum;
  int                 m_cnt;
  int                 dut_out;     // output transfers seen on the DUT pins

  function automatic logic [ACC_W-1:0] group_sum();
    logic signed [ACC_W-1:0] s;
    s = '0;
    foreach (grp[k]) s = s + {{(ACC_W-64){grp[k][63]}}, grp[k]};
    return s;
  endfunction

  task automatic model_reset();
    grp.delete();
    m_started = 1'b0;
    m_hold    = 1'b0;
    m_sum     = '0;
    m_cnt     = 0;
  endtask

  // One clock: apply the model to the inputs presented now, take the edge,
  // then compare the DUT against the model 1 ns later.
  task automatic step();
    if (out_valid && out_ready) dut_out++;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_hold) begin
      if (in_valid) begin
        grp.push_back(in_z);
        if (in_last || grp.size() == LEN) begin
          m_sum  = group_sum();
          m_cnt  = grp.size();
          m_hold = 1'b1;
          grp.delete();
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    check("in_ready", in_ready, (m_started && !m_hold));
    check("out_valid", out_valid, m_hold);
    if (m_hold) begin
      check("out_acc", out_acc, m_sum);
      check("out_cnt", out_cnt, 9'(m_cnt));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [7:0][63:0] z;
    logic [3:0]       n;
    logic             last;
    logic [ACC_W-1:0] exp_acc;
    logic [8:0]       exp_cnt;
  } gvec_t;

  gvec_t tbl [5];

  task automatic run_group(input int t);
    out_ready = 1'b1;
    for (int i = 0; i < int'(tbl[t].n); i++) begin
      in_valid = 1'b1;
      in_z     = tbl[t].z[i];
      in_last  = tbl[t].last && (i == int'(tbl[t].n) - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("tbl_valid", out_valid, 1'b1);
    check("tbl_acc", out_acc, tbl[t].exp_acc);
    check("tbl_cnt", out_cnt, tbl[t].exp_cnt);
    step();
    check("tbl_ready_after", in_ready, 1'b1);
  endtask

  initial begin
    int k;
    int base;
    logic [ACC_W-1:0] held_acc;
    logic [8:0]       held_cnt;

    for (int t = 0; t < 5; t++) tbl[t] = '0;
    for (int i = 0; i < 8; i++) begin
      tbl[0].z[i] = 64'(i + 1);
      tbl[1].z[i] = 64'h8000_0000_0000_0000;
      tbl[2].z[i] = 64'h7FFF_FFFF_FFFF_FFFF;
    end
    tbl[0].n = 4'd8; tbl[0].exp_acc = 72'd36;                   tbl[0].exp_cnt = 9'd8;
    tbl[1].n = 4'd8; tbl[1].exp_acc = 72'hFC_0000_0000_0000_0000; tbl[1].exp_cnt = 9'd8;
    tbl[2].n = 4'd8; tbl[2].exp_acc = 72'h03_FFFF_FFFF_FFFF_FFF8; tbl[2].exp_cnt = 9'd8;
    tbl[3].z[0] = 64'hFFFF_FFFF_FFFF_FFFB;
    tbl[3].z[1] = 64'd3;
    tbl[3].n = 4'd2; tbl[3].last = 1'b1;
    tbl[3].exp_acc = 72'hFF_FFFF_FFFF_FFFF_FFFE; tbl[3].exp_cnt = 9'd2;
    tbl[4].z[0] = 64'd7;
    tbl[4].n = 4'd1; tbl[4].last = 1'b1;
    tbl[4].exp_acc = 72'd7; tbl[4].exp_cnt = 9'd1;

    // ---- reset state ----
    rst = 1'b0; in_valid = 1'b0; in_z = '0; in_last = 1'b0; out_ready = 1'b0;
    dut_out = 0;
    model_reset();
    #3;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_acc", out_acc, '0);
    check("rst_out_cnt", out_cnt, '0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    check("pre_edge_in_ready", in_ready, 1'b0);
    step();   // first edge after release raises in_ready

    // ---- table groups: full, signed extremes, early close, single ----
    for (int t = 0; t < 5; t++) run_group(t);

    // ---- backpressure ----
    out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      in_valid = 1'b1; in_z = {$urandom, $urandom}; in_last = 1'b0;
      step();
    end
    held_acc = out_acc;
    held_cnt = out_cnt;
    in_valid = 1'b1; in_z = 64'd42; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_acc_stable", out_acc, held_acc);
      check("bp_cnt_stable", out_cnt, held_cnt);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_last   = 1'b0;
    step();   // output transfer; the held product waits one more edge
    step();   // held product 42 accepted
    in_z = 64'd1; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_acc", out_acc, 72'd43);
    check("bp_next_cnt", out_cnt, 9'd2);
    step();

    // ---- bubbles with in_last on the LEN-th product ----
    base = dut_out;
    k = 0;
    for (int c = 0; c < 200 && k < LEN; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_z     = {$urandom, $urandom};
      in_last  = (k == LEN - 1);
      step();
      if (in_valid) k++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("bub_products", 72'(k), 72'(LEN));
    check("bub_cnt", out_cnt, 9'(LEN));
    for (int i = 0; i < 3; i++) step();
    check("bub_one_output", 72'(dut_out - base), 72'd1);

    // ---- reset in the middle of a group ----
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_z = 64'd1000; in_last = 1'b0;
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_acc", out_acc, '0);
    check("mid_rst_out_cnt", out_cnt, '0);
    @(posedge clk);
    #1 check("mid_rst_no_pulse", out_valid, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    step();
    run_group(0);

    // ---- random traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_z      = {$urandom, $urandom};
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
